// File: rtl/proj_fm_pkg.sv
// rtl/proj_fm_pkg.sv - shared FM buffer state type and size helpers
package proj_fm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } fm_rd_state_t;

  function automatic int fm_buffer_size(input int rams, input int entries, input int offset);
    return rams * entries * offset;
  endfunction

  function automatic int fm_addr_bits(input int buffer_size);
    return (buffer_size > 1) ? $clog2(buffer_size) : 1;
  endfunction

  function automatic int fm_bidx_bits(input int buffer_count);
    return (buffer_count > 2) ? $clog2(buffer_count) : 1;
  endfunction

endpackage

// File: rtl/proj_fm_skid.sv
// rtl/proj_fm_skid.sv - 2-entry valid/ready FIFO absorbing RAM read latency
module proj_fm_skid #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_tdata,
  input  logic         i_tlast,
  output logic         o_tvalid,
  input  logic         i_tready,
  output logic [W-1:0] o_tdata,
  output logic         o_tlast,
  output logic [1:0]   o_occ
);

  logic [W:0] r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;
  logic       w_pop;
  logic [W:0] w_head;

  assign w_pop  = (r_occ != 2'd0) && i_tready;
  assign w_head = r_mem[r_rd_ptr];

  // Storage and pointers; the reader's credit scheme guarantees no push when full
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= {i_tlast, i_tdata};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head is zeroed while empty so stale words never show on the stream
  assign o_tvalid = (r_occ != 2'd0);
  assign o_tdata  = o_tvalid ? w_head[W-1:0] : '0;
  assign o_tlast  = o_tvalid & w_head[W];
  assign o_occ    = r_occ;

endmodule

// File: rtl/proj_fm_reader.sv
// rtl/proj_fm_reader.sv - ping-pong FM bank reader; PROJ_FM_READER_ERR_EN enables overrun flag
module proj_fm_reader
  import proj_fm_pkg::*;
#(
  parameter int BUFFER_COUNT         = 2,
  parameter int RAMS                 = 2,
  parameter int ENTRIES              = 4,
  parameter int OFFSET               = 8,
  parameter int DATA_BITS            = 8,
  parameter int READ_ADDRESSES_COUNT = 2,
  localparam int BUFFER_SIZE = fm_buffer_size(RAMS, ENTRIES, OFFSET),
  localparam int ADDR_BITS   = fm_addr_bits(BUFFER_SIZE),
  localparam int BIDX_BITS   = fm_bidx_bits(BUFFER_COUNT),
  localparam int WORD_BITS   = READ_ADDRESSES_COUNT * DATA_BITS
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_bank_full,
  input  logic [BIDX_BITS-1:0] in_bank_idx,
  output logic                 out_ren,
  output logic [BIDX_BITS-1:0] out_rbank,
  output logic [ADDR_BITS-1:0] out_raddr,
  input  logic [WORD_BITS-1:0] in_rdata,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_last,
  output logic                 out_bank_release,
  output logic [BIDX_BITS-1:0] out_release_idx,
  output logic                 out_busy,
  output logic                 out_err
);

  localparam int WORDS    = BUFFER_SIZE / READ_ADDRESSES_COUNT;
  localparam int CNT_BITS = $clog2(WORDS) + 1;
  localparam logic [CNT_BITS-1:0]  LAST_CNT = CNT_BITS'(WORDS - 1);
  localparam logic [BIDX_BITS-1:0] LAST_PTR = BIDX_BITS'(BUFFER_COUNT - 1);

  fm_rd_state_t          r_state;
  fm_rd_state_t          w_state_next;
  logic [BUFFER_COUNT-1:0] r_full;
  logic [BUFFER_COUNT-1:0] w_full_next;
  logic [BIDX_BITS-1:0]  r_ptr;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [1:0]            w_occ;
  logic                  w_pop;
  logic                  w_ren;
  logic                  w_issue_last;
  logic                  w_release;
  logic [2:0]            w_credit_lhs;
  logic [2:0]            w_credit_rhs;

  // A read may issue only if the skid buffer can still hold its data next cycle
  assign w_pop        = out_valid && in_ready;
  assign w_credit_lhs = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_credit_rhs = 3'd2 + {2'b00, w_pop};
  assign w_ren        = (r_state == READ) && (w_credit_lhs < w_credit_rhs);
  assign w_issue_last = w_ren && (r_cnt == LAST_CNT);
  assign w_release    = (r_state == RELEASE);

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: wait for the bank at ptr, stream it, let the last read land, release
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_full[r_ptr]) w_state_next = READ;
      READ:    if (w_issue_last) w_state_next = DRAIN;
      DRAIN:   w_state_next = RELEASE;
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Full flags: a writer set in the same cycle as our clear must not be lost
  always_comb begin
    w_full_next = r_full;
    if (w_release) w_full_next[r_ptr] = 1'b0;
    if (in_bank_full) w_full_next[in_bank_idx] = 1'b1;
  end

  // Bank flags and round-robin pointer
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_full <= '0;
      r_ptr  <= '0;
    end else begin
      r_full <= w_full_next;
      if (w_release) begin
        r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + BIDX_BITS'(1);
      end
    end
  end

  // Word counter and the one-cycle read-in-flight marker with its last tag
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (w_ren) begin
        r_cnt <= r_cnt + CNT_BITS'(1);
      end
      r_inflight      <= w_ren;
      r_inflight_last <= w_issue_last;
    end
  end

  proj_fm_skid #(
    .W (WORD_BITS)
  ) u_skid (
    .i_clk    (in_clk),
    .i_rst    (in_rst),
    .i_push   (r_inflight),
    .i_tdata  (in_rdata),
    .i_tlast  (r_inflight_last),
    .o_tvalid (out_valid),
    .i_tready (in_ready),
    .o_tdata  (out_data),
    .o_tlast  (out_last),
    .o_occ    (w_occ)
  );

  assign out_ren          = w_ren;
  assign out_rbank        = w_ren ? r_ptr : '0;
  assign out_raddr        = w_ren ? ADDR_BITS'(int'(r_cnt) * READ_ADDRESSES_COUNT) : '0;
  assign out_bank_release = w_release;
  assign out_release_idx  = w_release ? r_ptr : '0;
  assign out_busy         = (r_state != IDLE);

`ifdef PROJ_FM_READER_ERR_EN
  logic r_err;

  // Sticky overrun: the writer refilled a bank we have not yet released
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_err <= 1'b0;
    end else if (in_bank_full && r_full[in_bank_idx]) begin
      r_err <= 1'b1;
    end
  end

  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_proj_fm_reader.sv
// tb/tb_proj_fm_reader.sv - randomized self-checking bench for proj_fm_reader
module tb_proj_fm_reader;

  localparam int BC = 2, RAMS = 2, ENT = 4, OFF = 8, DB = 8, RAC = 2;
  localparam int BS = RAMS * ENT * OFF;
  localparam int WORDS = BS / RAC;
  localparam int AB = $clog2(BS);
  localparam int BB = 1;
  localparam int W = RAC * DB;
`ifdef PROJ_FM_READER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          in_clk = 1'b0;
  logic          in_rst;
  logic          in_bank_full;
  logic [BB-1:0] in_bank_idx;
  logic          out_ren;
  logic [BB-1:0] out_rbank;
  logic [AB-1:0] out_raddr;
  logic [W-1:0]  in_rdata;
  logic          out_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_bank_release;
  logic [BB-1:0] out_release_idx;
  logic          out_busy;
  logic          out_err;

  always #5 in_clk = ~in_clk;

  proj_fm_reader #(
    .BUFFER_COUNT(BC), .RAMS(RAMS), .ENTRIES(ENT), .OFFSET(OFF),
    .DATA_BITS(DB), .READ_ADDRESSES_COUNT(RAC)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_bank_full(in_bank_full), .in_bank_idx(in_bank_idx),
    .out_ren(out_ren), .out_rbank(out_rbank), .out_raddr(out_raddr), .in_rdata(in_rdata),
    .out_valid(out_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_bank_release(out_bank_release), .out_release_idx(out_release_idx),
    .out_busy(out_busy), .out_err(out_err)
  );

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } word_t;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] mem [BC][BS];
  word_t obs_words[$];
  int    obs_addr[$];
  int    obs_rel[$];
  int    rel_cyc[$];
  word_t exp_words[$];
  int    exp_addr[$];
  int    cyc = 0;
  int    first_valid_cyc, max_out, stall_viol, n_issued, n_popped;
  logic  pend_rd, prev_stall;
  int    pend_bank, pend_addr;
  word_t prev_word;

  function automatic logic [W-1:0] ram_word(input int b, input int a);
    logic [W-1:0] w;
    for (int i = 0; i < RAC; i++) w[i*DB +: DB] = mem[b % BC][(a + i) % BS];
    return w;
  endfunction

  // Expected stream: every word of each bank in order, lanes straight from the bank contents
  task automatic model_banks(input int nb, input int b0, input int b1);
    int    b;
    word_t w;
    exp_words.delete();
    exp_addr.delete();
    for (int j = 0; j < nb; j++) begin
      b = (j == 0) ? b0 : b1;
      for (int k = 0; k < WORDS; k++) begin
        w.data = ram_word(b, k * RAC);
        w.last = (k == WORDS - 1);
        exp_words.push_back(w);
        exp_addr.push_back(b * 256 + k * RAC);
      end
    end
  endtask

  task automatic clear_obs();
    obs_words.delete(); obs_addr.delete(); obs_rel.delete(); rel_cyc.delete();
    first_valid_cyc = -1; max_out = 0; stall_viol = 0; n_issued = 0; n_popped = 0;
    pend_rd = 1'b0; prev_stall = 1'b0; prev_word = '0;
  endtask

  // One clock: observe at the falling edge, then play the RAM after the rising edge
  task automatic tick();
    word_t cur;
    @(negedge in_clk);
    cur.last = out_last;
    cur.data = out_data;
    if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
    if (prev_stall && (!out_valid || cur !== prev_word)) stall_viol++;
    prev_stall = out_valid && !in_ready;
    prev_word  = cur;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && in_ready) begin
      obs_words.push_back(cur);
      n_popped++;
    end
    pend_rd = out_ren;
    if (out_ren) begin
      pend_bank = int'(out_rbank);
      pend_addr = int'(out_raddr);
      obs_addr.push_back(pend_bank * 256 + pend_addr);
      n_issued++;
    end
    if (out_bank_release) begin
      obs_rel.push_back(int'(out_release_idx));
      rel_cyc.push_back(cyc);
    end
    @(posedge in_clk);
    #1;
    in_rdata = pend_rd ? ram_word(pend_bank, pend_addr) : W'($urandom);
    cyc++;
  endtask

  task automatic pulse(input int idx);
    in_bank_full = 1'b1;
    in_bank_idx  = BB'(idx);
    tick();
    in_bank_full = 1'b0;
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run(input int nwords, input int nrel, input int mode, input int budget);
    int i = 0;
    while ((obs_words.size() < nwords || obs_rel.size() < nrel) && i < budget) begin
      case (mode)
        0:       in_ready = 1'b1;
        1:       in_ready = (i % 4 == 0) || (i % 4 == 3);
        default: in_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      i++;
    end
    in_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic reset_dut();
    in_rst = 1'b1;
    in_bank_full = 1'b0;
    in_bank_idx = '0;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    for (int b = 0; b < BC; b++)
      for (int a = 0; a < BS; a++) mem[b][a] = DB'($urandom);
    clear_obs();
  endtask

  task automatic test_reset();
    in_rst = 1'b1; in_bank_full = 1'b0; in_bank_idx = '0; in_ready = 1'b0; in_rdata = '0;
    clear_obs();
    repeat (2) @(posedge in_clk);
    #1;
    checks++;
    if ({out_ren, out_rbank, out_raddr, out_valid, out_data, out_last, out_bank_release,
         out_release_idx, out_busy, out_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ren=%b valid=%b data=%h busy=%b rel=%b err=%b exp all 0",
               out_ren, out_valid, out_data, out_busy, out_bank_release, out_err);
    end
    in_rst = 1'b0;
    in_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (n_issued !== 0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got reads=%0d busy=%b exp 0 0", n_issued, out_busy);
    end
  endtask

  task automatic test_single_bank();
    int start;
    reset_dut();
    in_ready = 1'b1;
    start = cyc;
    pulse(0);
    run(WORDS, 1, 0, 200);
    model_banks(1, 0, 0);
    checks++;
    if (first_valid_cyc - start !== 4) begin
      errors++;
      $display("FAIL single_latency got %0d exp 4", first_valid_cyc - start);
    end
    checks++;
    if (obs_words.size() !== WORDS || obs_addr.size() !== WORDS) begin
      errors++;
      $display("FAIL single_count got words=%0d reads=%0d exp %0d", obs_words.size(), obs_addr.size(), WORDS);
    end
    for (int k = 0; k < exp_words.size() && k < obs_words.size() && k < obs_addr.size(); k++) begin
      checks++;
      if (obs_words[k] !== exp_words[k] || obs_addr[k] !== exp_addr[k]) begin
        errors++;
        $display("FAIL single_word[%0d] got %h @%0d exp %h @%0d", k, obs_words[k], obs_addr[k], exp_words[k], exp_addr[k]);
      end
    end
    checks++;
    if (obs_rel.size() !== 1 || (obs_rel.size() > 0 && (obs_rel[0] !== 0 || rel_cyc[0] - start !== WORDS + 3))) begin
      errors++;
      $display("FAIL single_release got n=%0d idx=%0d at=%0d exp n=1 idx=0 at=%0d", obs_rel.size(),
               (obs_rel.size() > 0) ? obs_rel[0] : -1, (rel_cyc.size() > 0) ? rel_cyc[0] - start : -1, WORDS + 3);
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL single_outstanding got %0d exp <=2", max_out);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    in_ready = 1'b1;
    pulse(0);
    run(WORDS, 1, 1, 400);
    model_banks(1, 0, 0);
    checks++;
    if (obs_words.size() !== WORDS) begin
      errors++;
      $display("FAIL bp_count got %0d exp %0d", obs_words.size(), WORDS);
    end
    for (int k = 0; k < exp_words.size() && k < obs_words.size(); k++) begin
      checks++;
      if (obs_words[k] !== exp_words[k]) begin
        errors++;
        $display("FAIL bp_word[%0d] got %h exp %h", k, obs_words[k], exp_words[k]);
      end
    end
    checks++;
    if (stall_viol !== 0 || max_out > 2) begin
      errors++;
      $display("FAIL bp_stability got unstable=%0d outstanding=%0d exp 0 <=2", stall_viol, max_out);
    end
    checks++;
    if (obs_rel.size() !== 1 || (obs_rel.size() > 0 && obs_rel[0] !== 0)) begin
      errors++;
      $display("FAIL bp_release got n=%0d exp 1 release of bank 0", obs_rel.size());
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    in_ready = 1'b1;
    pulse(0);
    tick();
    pulse(1);
    run(2 * WORDS, 2, 2, 800);
    model_banks(2, 0, 1);
    checks++;
    if (obs_words.size() !== 2 * WORDS || obs_addr.size() !== 2 * WORDS) begin
      errors++;
      $display("FAIL b2b_count got words=%0d reads=%0d exp %0d", obs_words.size(), obs_addr.size(), 2 * WORDS);
    end
    for (int k = 0; k < exp_words.size() && k < obs_words.size() && k < obs_addr.size(); k++) begin
      checks++;
      if (obs_words[k] !== exp_words[k] || obs_addr[k] !== exp_addr[k]) begin
        errors++;
        $display("FAIL b2b_word[%0d] got %h @%0d exp %h @%0d", k, obs_words[k], obs_addr[k], exp_words[k], exp_addr[k]);
      end
    end
    checks++;
    if (obs_rel.size() !== 2 || (obs_rel.size() == 2 && (obs_rel[0] !== 0 || obs_rel[1] !== 1))) begin
      errors++;
      $display("FAIL b2b_release got n=%0d exp releases 0 then 1", obs_rel.size());
    end
    checks++;
    if (stall_viol !== 0 || max_out > 2) begin
      errors++;
      $display("FAIL b2b_stability got unstable=%0d outstanding=%0d exp 0 <=2", stall_viol, max_out);
    end
  endtask

  task automatic test_out_of_order();
    reset_dut();
    in_ready = 1'b1;
    pulse(1);
    repeat (20) tick();
    checks++;
    if (n_issued !== 0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL ooo_wait got reads=%0d busy=%b exp 0 0", n_issued, out_busy);
    end
    pulse(0);
    run(2 * WORDS, 2, 0, 400);
    model_banks(2, 0, 1);
    checks++;
    if (obs_words.size() !== 2 * WORDS || obs_addr.size() !== 2 * WORDS) begin
      errors++;
      $display("FAIL ooo_count got words=%0d reads=%0d exp %0d", obs_words.size(), obs_addr.size(), 2 * WORDS);
    end
    for (int k = 0; k < exp_words.size() && k < obs_words.size() && k < obs_addr.size(); k++) begin
      checks++;
      if (obs_words[k] !== exp_words[k] || obs_addr[k] !== exp_addr[k]) begin
        errors++;
        $display("FAIL ooo_word[%0d] got %h @%0d exp %h @%0d", k, obs_words[k], obs_addr[k], exp_words[k], exp_addr[k]);
      end
    end
    checks++;
    if (obs_rel.size() !== 2 || (obs_rel.size() == 2 && (obs_rel[0] !== 0 || obs_rel[1] !== 1))) begin
      errors++;
      $display("FAIL ooo_release got n=%0d exp releases 0 then 1", obs_rel.size());
    end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    reset_dut();
    in_ready = 1'b1;
    pulse(0);
    pulse(1);
    while (obs_words.size() < 10 && i < 100) begin
      tick();
      i++;
    end
    in_rst = 1'b1;
    #1;
    checks++;
    if ({out_ren, out_rbank, out_raddr, out_valid, out_data, out_last, out_bank_release,
         out_release_idx, out_busy, out_err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got ren=%b valid=%b data=%h busy=%b exp all 0",
               out_ren, out_valid, out_data, out_busy);
    end
    repeat (2) tick();
    in_rst = 1'b0;
    clear_obs();
    pulse(0);
    run(WORDS, 1, 0, 200);
    model_banks(1, 0, 0);
    checks++;
    if (obs_addr.size() !== WORDS || obs_words.size() !== WORDS) begin
      errors++;
      $display("FAIL midreset_count got reads=%0d words=%0d exp %0d (bank1 flag must be lost)",
               obs_addr.size(), obs_words.size(), WORDS);
    end
    for (int k = 0; k < exp_words.size() && k < obs_words.size() && k < obs_addr.size(); k++) begin
      checks++;
      if (obs_words[k] !== exp_words[k] || obs_addr[k] !== exp_addr[k]) begin
        errors++;
        $display("FAIL midreset_word[%0d] got %h @%0d exp %h @%0d", k, obs_words[k], obs_addr[k], exp_words[k], exp_addr[k]);
      end
    end
  endtask

  task automatic test_err();
    reset_dut();
    in_ready = 1'b1;
    checks++;
    if (out_err !== 1'b0) begin
      errors++;
      $display("FAIL err_initial got %b exp 0", out_err);
    end
    pulse(0);
    pulse(0);
    checks++;
    if (out_err !== ERR_EXP) begin
      errors++;
      $display("FAIL err_set got %b exp %b", out_err, ERR_EXP);
    end
    run(WORDS, 1, 0, 200);
    checks++;
    if (out_err !== ERR_EXP || obs_words.size() !== WORDS || obs_rel.size() !== 1) begin
      errors++;
      $display("FAIL err_held got err=%b words=%0d rel=%0d exp err=%b words=%0d rel=1",
               out_err, obs_words.size(), obs_rel.size(), ERR_EXP, WORDS);
    end
    reset_dut();
    checks++;
    if (out_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got %b exp 0", out_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_bank();
    test_backpressure();
    test_back_to_back();
    test_out_of_order();
    test_reset_mid();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proj_fm_reader.md
Name: proj_fm_reader

Overview:
Read-side controller for the ping-pong feature-map buffer.
- The FM writer signals each completely filled bank.
- This block drains that bank through a synchronous RAM read port as READ_ADDRESSES_COUNT-byte words on a valid/ready stream.
- It then releases the bank back to the writer.
- It sits between the FM bank storage and the downstream MinHash projection datapath.

Parameters:
BUFFER_COUNT, 2, number of ping-pong banks (>=2).
RAMS, 2, RAMs per bank.
ENTRIES, 4, entries per RAM.
OFFSET, 8, offset size per entry.
DATA_BITS, 8, bits per memory cell.
READ_ADDRESSES_COUNT, 2, cells per output word (power of two, divides BUFFER_SIZE).

Ports:
in_clk  input  1  clock; all logic on rising edge.
in_rst  input  1  reset, asynchronous, active-high.
in_bank_full  input  1  one-cycle pulse: bank in_bank_idx is filled.
in_bank_idx  input  BIDX_BITS  index of the filled bank.
out_ren  output  1  RAM read enable.
out_rbank  output  BIDX_BITS  bank being read.
out_raddr  output  ADDR_BITS  cell address of lane 0.
in_rdata  input  RAC*DATA_BITS  RAM data, valid the cycle after out_ren; lane i = cell raddr+i, lane 0 in the LSBs.
out_valid  output  1  stream word valid.
in_ready  input  1  downstream accepts.
out_data  output  RAC*DATA_BITS  stream word.
out_last  output  1  marks the final word of a bank.
out_bank_release  output  1  one-cycle pulse: bank freed.
out_release_idx  output  BIDX_BITS  index of the freed bank.
out_busy  output  1  state != IDLE.
out_err  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Derived values:
  - BUFFER_SIZE = RAMS*ENTRIES*OFFSET.
  - ADDR_BITS = clog2(BUFFER_SIZE).
  - BIDX_BITS = max(1, clog2(BUFFER_COUNT)).
  - WORDS = BUFFER_SIZE/READ_ADDRESSES_COUNT.
- Reset: all outputs are 0; state=IDLE; full flags=0; bank pointer ptr=0; word counter=0; skid buffer empty.
- Full flags: in_bank_full sets full[in_bank_idx]. The RELEASE state clears full[ptr]. If set and clear hit the same bank in the same cycle, set wins.
- Bank order: strict round-robin from ptr, matching the writer's fill order. A full bank other than ptr waits.
- FSM:
  - IDLE: if full[ptr], go to READ with cnt=0.
  - READ: issue a read when credit allows. On issue: out_rbank=ptr, out_raddr=cnt*RAC, cnt++. After issuing word WORDS-1, go to DRAIN.
  - DRAIN: one cycle; the last in_rdata is captured. Then go to RELEASE.
  - RELEASE: out_bank_release=1, out_release_idx=ptr; clear full[ptr]; ptr=(ptr+1) mod BUFFER_COUNT; go to IDLE.
- Credit: out_ren = (state==READ) && (occupancy + inflight - pop < 2).
  - occupancy: entries held in the 2-entry skid buffer.
  - inflight: read issued the previous cycle.
  - pop: out_valid && in_ready.
  - Result: 1 word/cycle when in_ready is held high; no word is ever dropped under backpressure.
- out_ren, out_rbank and out_raddr are combinational from registered state. out_data, out_valid and out_last are driven from the skid-buffer head.
- out_last is set on the word with cnt==WORDS-1.
- Latency: in_bank_full pulse in cycle 0 → first out_ren in cycle 2 → first out_valid in cycle 4.
- Stream rules: out_data and out_last stay stable while out_valid && !in_ready.
- Release timing: the release may precede acceptance of the final buffered words. The downstream consumer uses out_last, not release, for word framing.
- Reset mid-operation: all state returns to reset values immediately. Pending full flags are lost; the writer restarts from bank 0.
- Address arithmetic: out_raddr is cnt*RAC, zero-extended to ADDR_BITS and never wraps within a bank. cnt is clog2(WORDS)+1 bits.

Optional Feature:
Macro: PROJ_FM_READER_ERR_EN.
- Defined: out_err is set when in_bank_full targets a bank whose full flag is already 1 (writer overran the reader). It stays set until in_rst.
- Undefined: out_err is tied to 0 and no detection logic exists.

Decomposition:
- Package proj_fm_pkg:
  - state enum fm_rd_state_t {IDLE, READ, DRAIN, RELEASE}.
  - functions computing BUFFER_SIZE, ADDR_BITS and BIDX_BITS from the parameters.
  - these are shared with the writer-side FM buffer.
- Sub-module proj_fm_skid: 2-entry valid/ready FIFO for {last, data} with occupancy output. The RAM latency and backpressure handling live here.

Test Plan:
- Single bank, defaults: pulse in_bank_full idx0, in_ready=1.
  - 32 words, out_raddr 0,2,…,62, one per cycle.
  - out_last on word 32 only.
  - out_bank_release idx0 follows DRAIN.
  - first out_valid exactly 4 cycles after the pulse.
- Backpressure: in_ready toggled 1,0,0,1 repeatedly → no word lost or duplicated; out_data stable while stalled; inflight+occupancy never exceeds 2.
- Back-to-back banks: pulses idx0 then idx1 two cycles apart → 64 words total, bank 0 words first; releases idx0 then idx1.
- Out-of-order fill: pulse idx1 alone → no out_ren. Then pulse idx0 → bank 0 is read first, then bank 1.
- Reset mid-read: assert in_rst at word 10 → all outputs 0 asynchronously. After deassert, a pulse idx0 restarts reading at raddr 0.
- With PROJ_FM_READER_ERR_EN: pulse idx0 twice before release → out_err=1 and held. Without the macro, out_err stays 0.
